channel_accumulator: RTL and testbench

- Downstream of the per-window summation stage in the convolution datapath.
- Each 16-bit signed window sum is one input channel's contribution to one output pixel.
- Accumulates num_channels such sums onto a preloaded bias, saturates to 16 bits, applies optional ReLU, and presents one output pixel over a valid/ready handshake.
- One accumulation job runs at a time.

---
 rtl/channel_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_channel_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_accumulator.sv
// -----------------------------------------------------------------------------
// channel_accumulator
//
// Accumulates num_channels signed window sums (one per input channel) onto a
// preloaded bias, saturates the total to DATA_W bits, optionally rectifies it
// (ReLU) and presents the finished output pixel over a valid/ready handshake.
// Only one accumulation job is in flight at a time.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (priority over all inputs)
//   start        one-cycle pulse, loads job configuration (IDLE only)
//   num_channels channel count for the job, sampled on start
//   bias         signed bias, sampled on start
//   relu_en      1 = clamp negative result to 0, sampled on start
//   sum_valid    sum_in carries a valid channel sum
//   sum_in       signed channel sum from the summation stage
//   sum_ready    block accepts sum_in this cycle (high in ACCUM)
//   out_valid    out_data holds a finished pixel (high in OUTPUT)
//   out_data     saturated, optionally rectified result
//   out_ready    consumer accepts out_data
//   busy         high in any state other than IDLE
//
// All outputs are either registers or decoded from the state register, so
// there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module channel_accumulator #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 8,
  parameter int ACC_W  = 24   // must be >= DATA_W + CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   num_channels,
  input  logic [DATA_W-1:0] bias,
  input  logic              relu_en,
  input  logic              sum_valid,
  input  logic [DATA_W-1:0] sum_in,
  output logic              sum_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [CH_W-1:0]     count_reg, count_next;
  logic [CH_W-1:0]     nch_reg, nch_next;
  logic                relu_reg, relu_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;

  logic [ACC_W-1:0]    bias_ext;
  logic [ACC_W-1:0]    sum_ext;
  logic [ACC_W-1:0]    acc_sum;
  logic [CH_W-1:0]     last_idx;

  // Sign extension of the DATA_W inputs into the accumulator width.
  assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign sum_ext  = {{(ACC_W-DATA_W){sum_in[DATA_W-1]}}, sum_in};
  assign acc_sum  = acc_reg + sum_ext;

  // Index of the final transfer. Only meaningful in ACCUM, where nch_reg is
  // guaranteed non-zero, so the subtraction never wraps there.
  assign last_idx = nch_reg - CH_W'(1);

  // Saturate an accumulator value to the signed DATA_W range, then apply
  // ReLU if requested. The accumulator itself is wide enough never to wrap,
  // so clamping happens only here.
  function automatic logic [DATA_W-1:0] finalize(
    input logic [ACC_W-1:0] x,
    input logic             relu
  );
    logic signed [ACC_W-1:0] xs;
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    logic [DATA_W-1:0]       res;
    xs      = signed'(x);
    sat_max = signed'({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    sat_min = signed'({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
    if (xs > sat_max) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (xs < sat_min) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = x[DATA_W-1:0];
    end
    if (relu && res[DATA_W-1]) begin
      res = '0;
    end
    return res;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      count_reg    <= '0;
      nch_reg      <= '0;
      relu_reg     <= 1'b0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      nch_reg      <= nch_next;
      relu_reg     <= relu_next;
      out_data_reg <= out_data_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    nch_next      = nch_reg;
    relu_next     = relu_reg;
    out_data_next = out_data_reg;

    case (state_reg)
      IDLE: begin
        // sum_valid is deliberately ignored here.
        if (start) begin
          nch_next  = num_channels;
          relu_next = relu_en;
          if (num_channels != '0) begin
            acc_next   = bias_ext;
            count_next = '0;
            state_next = ACCUM;
          end else begin
            // Zero-channel job: the pixel is just the finalized bias. The
            // live relu_en is used because the latch is updated this cycle.
            out_data_next = finalize(bias_ext, relu_en);
            state_next    = OUTPUT;
          end
        end
      end

      ACCUM: begin
        // sum_ready is 1 in this state, so sum_valid alone marks a transfer.
        // start is ignored while busy.
        if (sum_valid) begin
          acc_next   = acc_sum;
          count_next = count_reg + CH_W'(1);
          if (count_reg == last_idx) begin
            out_data_next = finalize(acc_sum, relu_reg);
            state_next    = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        // out_data_reg holds steady here and after the handshake.
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state or taken straight from registers.
  assign sum_ready = (state_reg == ACCUM);
  assign out_valid = (state_reg == OUTPUT);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_channel_accumulator.sv
// -----------------------------------------------------------------------------
// tb_channel_accumulator
//
// Self-checking bench: directed jobs from the test plan plus randomized jobs,
// all compared against a plain-arithmetic reference of the pixel computation.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_channel_accumulator;

  localparam int DATA_W = 16;
  localparam int CH_W   = 8;
  localparam int ACC_W  = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CH_W-1:0]   num_channels = '0;
  logic [DATA_W-1:0] bias = '0;
  logic              relu_en = 1'b0;
  logic              sum_valid = 1'b0;
  logic [DATA_W-1:0] sum_in = '0;
  logic              sum_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  channel_accumulator #(
    .DATA_W(DATA_W),
    .CH_W  (CH_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_channels(num_channels),
    .bias        (bias),
    .relu_en     (relu_en),
    .sum_valid   (sum_valid),
    .sum_in      (sum_in),
    .sum_ready   (sum_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference pixel: exact integer sum, clamp to int16, optional ReLU.
  function automatic int ref_pixel(input int b, input int s[$], input bit relu);
    longint total;
    total = b;
    foreach (s[i]) total += s[i];
    if (total > 32767)  total = 32767;
    if (total < -32768) total = -32768;
    if (relu && total < 0) total = 0;
    return int'(total);
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int dout();
    return int'($signed(out_data));
  endfunction

  // Run one job: start, feed sums with random bubbles, check the pixel,
  // optionally stall the consumer, then complete the handshake.
  task automatic run_job(input string name, input int nch, input int b,
                         input bit relu, input int sums[$], input int bubble_pct,
                         input int hold_cycles, input bit poke_start);
    int exp, cyc, sent, early, guard, t;
    bit stable;
    logic [DATA_W-1:0] held;
    exp = ref_pixel(b, sums, relu);

    @(negedge clk);
    start        = 1'b1;
    num_channels = nch[CH_W-1:0];
    bias         = b[DATA_W-1:0];
    relu_en      = relu;
    @(negedge clk);
    cyc   = 1;
    start = 1'b0;
    // Scramble config after start: it must have been sampled already.
    num_channels = CH_W'($urandom);
    bias         = DATA_W'($urandom);
    relu_en      = 1'($urandom);

    sent = 0; early = 0; guard = 0;
    while (sent < nch && guard < 3000) begin
      if (out_valid) early++;
      sum_valid = ($urandom_range(99) >= bubble_pct);
      if (sum_valid) begin
        t = sums[sent];
        sum_in = t[DATA_W-1:0];
      end else begin
        sum_in = DATA_W'($urandom);
      end
      if (poke_start && sent == nch / 2) begin
        start        = 1'b1;
        num_channels = CH_W'($urandom);
        bias         = DATA_W'($urandom);
        relu_en      = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (sum_valid && sum_ready) sent++;
      @(negedge clk);
      cyc++;
      guard++;
    end
    sum_valid = 1'b0;
    start     = 1'b0;

    if (nch > 0) begin
      chk({name, " no_early_valid"}, early, 0);
      chk({name, " transfers"}, sent, nch);
    end
    chk({name, " out_valid"}, int'(out_valid), 1);
    chk({name, " out_data"}, dout(), exp);
    chk({name, " sum_ready_in_output"}, int'(sum_ready), 0);
    if (bubble_pct == 0) chk({name, " latency"}, cyc, nch + 1);

    if (hold_cycles > 0) begin
      held   = out_data;
      stable = 1'b1;
      for (int i = 0; i < hold_cycles; i++) begin
        out_ready = 1'b0;
        @(negedge clk);
        if (!out_valid || out_data !== held || sum_ready || !busy) stable = 1'b0;
      end
      chk({name, " hold_stable"}, int'(stable), 1);
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " valid_fell"}, int'(out_valid), 0);
    chk({name, " busy_fell"}, int'(busy), 0);
    chk({name, " data_retained"}, dout(), exp);
    $display("job %s nch=%0d bias=%0d relu=%0d result=%0d expected=%0d",
             name, nch, b, relu, dout(), exp);
  endtask

  initial begin
    int q[$];
    int n, b;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset sum_ready", int'(sum_ready), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", dout(), 0);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;

    // sum_valid in IDLE must be ignored.
    @(negedge clk);
    sum_valid = 1'b1;
    sum_in    = 16'd1234;
    repeat (3) @(negedge clk);
    sum_valid = 1'b0;
    chk("idle ignores sum_valid", int'(busy), 0);

    // Basic.
    q.delete(); q.push_back(100); q.push_back(-50); q.push_back(20);
    run_job("basic", 3, 10, 1'b0, q, 0, 0, 1'b0);

    // Saturation and ReLU.
    q.delete(); q.push_back(30000); q.push_back(30000);
    run_job("sat_pos", 2, 0, 1'b0, q, 0, 0, 1'b0);
    q.delete(); q.push_back(-30000); q.push_back(-30000);
    run_job("sat_neg", 2, 0, 1'b0, q, 0, 0, 1'b0);
    run_job("sat_neg_relu", 2, 0, 1'b1, q, 0, 0, 1'b0);

    // Handshake stress: bubbles plus a stalled consumer.
    q.delete(); repeat (4) q.push_back(1000);
    run_job("bubbles", 4, -4000, 1'b0, q, 50, 5, 1'b0);

    // Edge configs.
    q.delete();
    run_job("zero_ch", 0, -5, 1'b0, q, 0, 0, 1'b0);
    run_job("zero_ch_relu", 0, -5, 1'b1, q, 0, 0, 1'b0);
    q.delete(); q.push_back(7); q.push_back(-3); q.push_back(11); q.push_back(2);
    run_job("start_in_accum", 4, 50, 1'b0, q, 20, 0, 1'b1);

    // Reset mid-operation after 2 of 4 sums.
    @(negedge clk);
    start = 1'b1; num_channels = 8'd4; bias = 16'd7; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0; sum_valid = 1'b1; sum_in = 16'd100;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; sum_valid = 1'b1; sum_in = 16'd5; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; sum_valid = 1'b0; start = 1'b0;
    chk("midreset sum_ready", int'(sum_ready), 0);
    chk("midreset out_valid", int'(out_valid), 0);
    chk("midreset out_data", dout(), 0);
    chk("midreset busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("midreset no_output", int'(out_valid), 0);
    q.delete(); q.push_back(2); q.push_back(3);
    run_job("after_reset", 2, 1, 1'b0, q, 0, 0, 1'b0);

    // Max length, most negative everything.
    q.delete(); repeat (255) q.push_back(-32768);
    run_job("max_len", 255, -32768, 1'b0, q, 0, 0, 1'b0);
    q.delete(); repeat (255) q.push_back(32767);
    run_job("max_len_pos", 255, 32767, 1'b0, q, 10, 1, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      n = int'($urandom_range(20));
      b = rand_s16();
      q.delete();
      for (int k = 0; k < n; k++) begin
        if (j % 3 == 0) q.push_back(int'($urandom_range(4000)) - 2000);
        else            q.push_back(rand_s16());
      end
      run_job($sformatf("rand%0d", j), n, b, 1'($urandom), q,
              int'($urandom_range(60)), int'($urandom_range(3)),
              1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
